hud_digit_loader: RTL

- Controller that sequences updates of the 13-digit HUD readout.
- Accepts a binary value from game logic and converts it to BCD with sequential double-dabble.
- Waits for vertical blanking, then writes one digit per cycle into the digit sprite registers via one-hot write_num strobes and a shared out_num bus.
- Sits between score/tempo logic and the hud_digits sprite array, so displayed digits never change mid-frame.

---
 rtl/hud_pkg.sv | 19 +
 rtl/bin_to_bcd_seq.sv | 52 +++++
 rtl/hud_digit_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hud_pkg.sv
// Shared constants and state encoding for the HUD digit loader and its BCD converter.
package hud_pkg;

   localparam int NUM_DIGITS   = 13;
   localparam int VALUE_W      = 44;
   localparam int VBLANK_START = 768;

   localparam logic [3:0]  BLANK_CODE  = 4'hA;
   // Largest value that fits in NUM_DIGITS decimal digits
   localparam logic [63:0] MAX_DISPLAY = 64'd9_999_999_999_999;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      CONVERT     = 2'd1,
      WAIT_VBLANK = 2'd2,
      WRITE       = 2'd3
   } hud_state_e;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one shift-and-correct step per clock, VALUE_W steps per conversion.
module bin_to_bcd_seq
   import hud_pkg::*;
#(
   parameter int VALUE_W    = hud_pkg::VALUE_W,
   parameter int NUM_DIGITS = hud_pkg::NUM_DIGITS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [VALUE_W-1:0]        bin_in,
   output logic                      last,
   output logic [NUM_DIGITS*4-1:0]   bcd
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int CNT_W = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] shreg;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   bcd_adj;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   // last is high during the cycle whose closing edge performs the final step,
   // so the caller can leave its convert state on exactly that edge.
   assign last = (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         bcd   <= '0;
         cnt   <= '0;
      end else if (start) begin
         shreg <= bin_in;
         bcd   <= '0;
         cnt   <= CNT_W'(VALUE_W);
      end else if (cnt != '0) begin
         bcd   <= (bcd_adj << 1) | BCD_W'(shreg[VALUE_W-1]);
         shreg <= shreg << 1;
         cnt   <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/hud_digit_loader.sv
// Converts a binary score to BCD, waits for vertical blanking, then strobes one digit per cycle
// into the HUD digit sprites so the readout never changes mid-frame.
//
// state       | meaning
// IDLE        | ready for a request; value accepted on value_valid
// CONVERT     | double-dabble running, VALUE_W cycles
// WAIT_VBLANK | BCD ready, holding until vcount reaches blanking
// WRITE       | one write_num strobe per cycle, digit 0 (MSD) first
module hud_digit_loader
   import hud_pkg::*;
#(
   parameter int         NUM_DIGITS    = hud_pkg::NUM_DIGITS,
   parameter int         VALUE_W       = hud_pkg::VALUE_W,
   parameter int         VBLANK_START  = hud_pkg::VBLANK_START,
   parameter int         BLANK_LEADING = 1,
   parameter logic [3:0] BLANK_CODE    = hud_pkg::BLANK_CODE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [9:0]             vcount,
   input  logic [VALUE_W-1:0]     value,
   input  logic                   value_valid,
   output logic                   ready,
   output logic [NUM_DIGITS-1:0]  write_num,
   output logic [3:0]             out_num,
   output logic                   busy,
   output logic                   done
);

   localparam int               DIG_W    = $clog2(NUM_DIGITS);
   localparam logic [DIG_W-1:0] LAST_IDX = DIG_W'(NUM_DIGITS - 1);

   hud_state_e                state;
   logic [DIG_W-1:0]          k;
   logic                      seen_nz;
   logic                      conv_start;
   logic                      conv_last;
   logic [VALUE_W-1:0]        value_sat;
   logic [NUM_DIGITS*4-1:0]   bcd;
   logic                      in_vblank;
   logic [DIG_W-1:0]          nxt_idx;
   logic [3:0]                nxt_dig;
   logic                      nxt_nz;
   logic [3:0]                nxt_code;

   function automatic logic [3:0] bcd_digit(input logic [NUM_DIGITS*4-1:0] b,
                                            input logic [DIG_W-1:0]        idx);
      logic [3:0] d;
      d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (DIG_W'(i) == idx) begin
            d = b[(NUM_DIGITS-1-i)*4 +: 4];
         end
      end
      return d;
   endfunction

   // ready is only high in IDLE, so this is the accept condition; the converter
   // loads on the same edge the FSM leaves IDLE.
   assign conv_start = ready && value_valid;
   assign value_sat  = (64'(value) > MAX_DISPLAY) ? VALUE_W'(MAX_DISPLAY) : value;
   assign in_vblank  = (vcount >= 10'(VBLANK_START));

   bin_to_bcd_seq #(
      .VALUE_W    (VALUE_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bcd (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (conv_start),
      .bin_in (value_sat),
      .last   (conv_last),
      .bcd    (bcd)
   );

   // Code for the digit driven on the next edge; leading zeros blank until the
   // first nonzero digit, and the last position always shows a numeral.
   always_comb begin
      nxt_idx  = (state == WRITE) ? k + DIG_W'(1) : '0;
      nxt_dig  = bcd_digit(bcd, nxt_idx);
      nxt_nz   = ((state == WRITE) && seen_nz) || (nxt_dig != 4'd0);
      nxt_code = nxt_dig;
      if ((BLANK_LEADING != 0) && !nxt_nz && (nxt_idx != LAST_IDX)) begin
         nxt_code = BLANK_CODE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         write_num <= '0;
         out_num   <= '0;
         k         <= '0;
         seen_nz   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (value_valid) begin
                  state <= CONVERT;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            CONVERT: begin
               if (conv_last) begin
                  state <= WAIT_VBLANK;
               end
            end
            WAIT_VBLANK: begin
               if (in_vblank) begin
                  state     <= WRITE;
                  k         <= '0;
                  write_num <= NUM_DIGITS'(1);
                  out_num   <= nxt_code;
                  seen_nz   <= nxt_nz;
               end
            end
            WRITE: begin
               if (k == LAST_IDX) begin
                  state     <= IDLE;
                  k         <= '0;
                  write_num <= '0;
                  out_num   <= '0;
                  seen_nz   <= 1'b0;
                  done      <= 1'b1;
                  ready     <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  k         <= k + DIG_W'(1);
                  write_num <= write_num << 1;
                  out_num   <= nxt_code;
                  seen_nz   <= nxt_nz;
               end
            end
            default: begin
               state     <= IDLE;
               ready     <= 1'b1;
               busy      <= 1'b0;
               write_num <= '0;
               out_num   <= '0;
            end
         endcase
      end
   end

endmodule
